// File: rtl/universal_shift_register_n.sv
// ---------------------------------------------------------------------------
// universal_shift_register_n
//
// Purpose:
//   WIDTH-bit universal register in the style of the 74LS194. It offers
//   parallel load, hold, single-step shift left/right with optional rotate,
//   and a multi-step shift engine. A START pulse with a count runs CNT shifts
//   on its own and reports progress on BUSY and DONE. All state changes on the
//   rising clock edge, and there are no asynchronous paths.
//
// Ports:
//   CLK    in   1      rising-edge clock
//   CLR_n  in   1      synchronous active-low clear (highest priority)
//   PR_n   in   1      synchronous active-low preset to all ones
//   S      in   2      mode: 00 hold, 01 shift right, 10 shift left, 11 load
//   D      in   WIDTH  parallel load data
//   DSR    in   1      serial input for shift right (enters Q[0])
//   DSL    in   1      serial input for shift left (enters Q[WIDTH-1])
//   ROT    in   1      rotate: the shifted-out bit re-enters, DSR/DSL ignored
//   START  in   1      begin a multi-step shift, with direction taken from S
//   CNT    in   CW     number of shift steps for START
//   Q      out  WIDTH  register contents
//   Q_n    out  WIDTH  exact complement of Q
//   BUSY   out  1      multi-step shift in progress
//   DONE   out  1      one-cycle pulse after the final step
// ---------------------------------------------------------------------------
module universal_shift_register_n #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             PR_n,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] D,
  input  logic             DSR,
  input  logic             DSL,
  input  logic             ROT,
  input  logic             START,
  input  logic [CW-1:0]    CNT,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_q,    q_d;
  state_e           state_q, state_d;
  logic [CW-1:0]    rem_q,  rem_d;   // shifts still to perform while in RUN
  logic             left_q, left_d;  // latched direction for the run
  logic             rot_q,  rot_d;   // latched rotate flag for the run
  logic             done_q, done_d;

  // One shift step. "Right" moves bits toward the MSB, so the serial input
  // enters Q[0]. This follows the 74LS194 naming, not the arithmetic naming.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] q,
    input logic             left,
    input logic             rot,
    input logic             dsr,
    input logic             dsl
  );
    logic sin;
    if (left) begin
      sin = rot ? q[0] : dsl;
      return {sin, q[WIDTH-1:1]};
    end else begin
      sin = rot ? q[WIDTH-1] : dsr;
      return {q[WIDTH-2:0], sin};
    end
  endfunction

  // NOTE: every output of this block gets a default first. A path that forgets
  // an assignment then keeps the register value instead of inferring a latch.
  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    rem_d   = rem_q;
    left_d  = left_q;
    rot_d   = rot_q;
    done_d  = 1'b0;

    if (!PR_n) begin
      // Preset aborts any run silently. No DONE pulse follows.
      q_d     = '1;
      state_d = IDLE;
      rem_d   = '0;
    end else if (state_q == RUN) begin
      // DSR/DSL stay live while direction and rotate come from the latched copy.
      q_d = shift_step(q_q, left_q, rot_q, DSR, DSL);
      if (rem_q <= CW'(1)) begin
        state_d = IDLE;
        rem_d   = '0;
        done_d  = 1'b1;
      end else begin
        rem_d = rem_q - CW'(1);
      end
    end else if (START && (S == MODE_RIGHT || S == MODE_LEFT)) begin
      left_d = (S == MODE_LEFT);
      rot_d  = ROT;
      if (CNT == '0) begin
        done_d = 1'b1;
      end else begin
        q_d = shift_step(q_q, S == MODE_LEFT, ROT, DSR, DSL);
        if (CNT == CW'(1)) begin
          done_d = 1'b1;
        end else begin
          state_d = RUN;
          rem_d   = CNT - CW'(1);
        end
      end
    end else begin
      unique case (S)
        MODE_HOLD:  q_d = q_q;
        MODE_RIGHT: q_d = shift_step(q_q, 1'b0, ROT, DSR, DSL);
        MODE_LEFT:  q_d = shift_step(q_q, 1'b1, ROT, DSR, DSL);
        MODE_LOAD:  q_d = D;
        default:    q_d = q_q;
      endcase
    end
  end

  // NOTE: the clear is sampled on the clock edge only, and state registers use
  // non-blocking assignments so that every flop updates from pre-edge values.
  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      q_q     <= '0;
      state_q <= IDLE;
      rem_q   <= '0;
      left_q  <= 1'b0;
      rot_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      left_q  <= left_d;
      rot_q   <= rot_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign Q_n  = ~q_q;
  // DONE is only set on the transition out of RUN (or a short START from
  // IDLE), so it never overlaps BUSY.
  assign BUSY = (state_q == RUN);
  assign DONE = done_q;

endmodule

// File: tb/tb_universal_shift_register_n.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_register_n
//
// Purpose:
//   Directed self-checking bench for universal_shift_register_n (WIDTH=8).
//   Inputs change and outputs are sampled on the falling edge. The DUT acts
//   on the rising edge in between.
// ---------------------------------------------------------------------------
module tb_universal_shift_register_n;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic             CLK = 1'b0;
  logic             CLR_n, PR_n;
  logic [1:0]       S;
  logic [WIDTH-1:0] D;
  logic             DSR, DSL, ROT, START;
  logic [CW-1:0]    CNT;
  logic [WIDTH-1:0] Q, Q_n;
  logic             BUSY, DONE;

  int n_vec  = 0;
  int n_miss = 0;

  universal_shift_register_n #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .CLR_n (CLR_n),
    .PR_n  (PR_n),
    .S     (S),
    .D     (D),
    .DSR   (DSR),
    .DSL   (DSL),
    .ROT   (ROT),
    .START (START),
    .CNT   (CNT),
    .Q     (Q),
    .Q_n   (Q_n),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle at the following falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    START = 1'b0; S = 2'b11; D = v;
    step();
    S = 2'b00;
  endtask

  int done_pulses;
  int overlap;

  initial begin
    CLR_n = 1'b1; PR_n = 1'b1; S = 2'b00; D = '0;
    DSR = 1'b0; DSL = 1'b0; ROT = 1'b0; START = 1'b0; CNT = '0;

    // Clear with every other input random.
    CLR_n = 1'b0;
    PR_n  = 1'($urandom); S = 2'($urandom); D = 8'($urandom);
    DSR   = 1'($urandom); DSL = 1'($urandom); ROT = 1'($urandom);
    START = 1'($urandom); CNT = CW'($urandom);
    step();
    check("clr_q",    Q,    8'h00);
    check("clr_qn",   Q_n,  8'hFF);
    check("clr_busy", BUSY, 1'b0);
    check("clr_done", DONE, 1'b0);
    CLR_n = 1'b1; PR_n = 1'b1; START = 1'b0; ROT = 1'b0; S = 2'b00;

    // Load, shift right with DSR, shift left with DSL, hold.
    load(8'hA5);
    check("load_q", Q, 8'hA5);
    S = 2'b01; DSR = 1'b1;
    step();
    check("shr_q", Q, 8'h4B);
    S = 2'b10; DSL = 1'b0;
    step();
    check("shl_q",  Q,   8'h25);
    check("shl_qn", Q_n, 8'hDA);
    S = 2'b00;
    step();
    check("hold_q", Q, 8'h25);

    // Rotate right 3 steps from 81. D and S are changed mid-run to show they
    // are ignored.
    load(8'h81);
    START = 1'b1; S = 2'b01; ROT = 1'b1; CNT = CW'(3);
    step();
    check("rr_q1", Q, 8'h03);
    check("rr_b1", BUSY, 1'b1);
    check("rr_d1", DONE, 1'b0);
    START = 1'b0; S = 2'b11; D = 8'h00; ROT = 1'b0;
    step();
    check("rr_q2", Q, 8'h06);
    check("rr_b2", BUSY, 1'b1);
    S = 2'b00;
    step();
    check("rr_q3", Q, 8'h0C);
    check("rr_b3", BUSY, 1'b0);
    check("rr_d3", DONE, 1'b1);
    step();
    check("rr_d4", DONE, 1'b0);
    check("rr_q4", Q, 8'h0C);

    // Rotate left 8 steps: Q must return to 5A with exactly one DONE pulse.
    load(8'h5A);
    START = 1'b1; S = 2'b10; ROT = 1'b1; CNT = CW'(8);
    done_pulses = 0; overlap = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      START = 1'b0; S = 2'b00;
      if (DONE) done_pulses++;
      if (DONE && BUSY) overlap++;
      if (i == 7) begin
        check("rl8_q",    Q,    8'h5A);
        check("rl8_done", DONE, 1'b1);
      end
    end
    check("rl8_pulses",  done_pulses, 1);
    check("rl8_overlap", overlap,     0);

    // Preset mid-run aborts with no DONE pulse. Then a CNT=0 start holds Q.
    load(8'h01);
    ROT = 1'b0; DSR = 1'b0;
    START = 1'b1; S = 2'b01; CNT = CW'(5);
    step();
    check("pr_q1", Q, 8'h02);
    START = 1'b0; PR_n = 1'b0;
    step();
    check("pr_q",    Q,    8'hFF);
    check("pr_busy", BUSY, 1'b0);
    check("pr_done", DONE, 1'b0);
    PR_n = 1'b1; S = 2'b00;
    step();
    check("pr_nodone", DONE, 1'b0);
    START = 1'b1; S = 2'b01; CNT = '0;
    step();
    check("c0_q",    Q,    8'hFF);
    check("c0_done", DONE, 1'b1);
    check("c0_busy", BUSY, 1'b0);
    START = 1'b0; S = 2'b00;
    step();
    check("c0_done2", DONE, 1'b0);

    // CNT=1 gives one shift with no BUSY. A START in the DONE cycle is taken.
    load(8'h01);
    ROT = 1'b0; DSR = 1'b1;
    START = 1'b1; S = 2'b01; CNT = CW'(1);
    step();
    check("c1_q",    Q,    8'h03);
    check("c1_busy", BUSY, 1'b0);
    check("c1_done", DONE, 1'b1);
    CNT = CW'(2); DSR = 1'b0;
    step();
    check("b2b_q1",   Q,    8'h06);
    check("b2b_busy", BUSY, 1'b1);
    check("b2b_d1",   DONE, 1'b0);
    START = 1'b0; S = 2'b00;
    step();
    check("b2b_q2", Q,    8'h0C);
    check("b2b_d2", DONE, 1'b1);
    check("b2b_b2", BUSY, 1'b0);

    // Left run without rotate: DSL is sampled live on each step, and the
    // direction stays latched even when S flips.
    load(8'h00);
    ROT = 1'b0; DSL = 1'b1;
    START = 1'b1; S = 2'b10; CNT = CW'(2);
    step();
    check("live_q1", Q, 8'h80);
    START = 1'b0; S = 2'b01; DSL = 1'b0; DSR = 1'b1;
    step();
    check("live_q2",   Q,    8'h40);
    check("live_done", DONE, 1'b1);

    // Clear mid-run discards the remaining count.
    load(8'h01);
    START = 1'b1; S = 2'b01; ROT = 1'b1; CNT = CW'(6);
    step();
    START = 1'b0; CLR_n = 1'b0;
    step();
    CLR_n = 1'b1; S = 2'b00;
    check("clrrun_q",    Q,    8'h00);
    check("clrrun_busy", BUSY, 1'b0);
    step();
    check("clrrun_done", DONE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
